// File: rtl/reg_read_port_pkg.sv
// Shared constants and response-buffer state encoding for the register read port.
package reg_read_port_pkg;

  localparam int DATA_W = 16;
  localparam int AW     = 3;
  localparam int NREG   = 2 ** AW;

  // The response buffer state doubles as resp_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage : reg_read_port_pkg

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one bit per register with a pending producer.
// Also gives the two-operand hazard lookup, where a same-cycle writeback
// counts as resolved because its data is bypassed.
module reg_scoreboard
  import reg_read_port_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [AW-1:0]   set_idx,
  input  logic            clr_en,
  input  logic [AW-1:0]   clr_idx,
  input  logic [AW-1:0]   ra,
  input  logic [AW-1:0]   rb,
  output logic [NREG-1:0] busy,
  output logic            hazard
);

  logic haz_a;
  logic haz_b;

  // Hazard lookup for both operands, masking a register being written back now.
  always_comb begin
    haz_a  = busy[ra] && !(clr_en && (clr_idx == ra));
    haz_b  = busy[rb] && !(clr_en && (clr_idx == rb));
    hazard = haz_a || haz_b;
  end

  // Busy vector update; the set is applied after the clear so a new producer wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      busy <= '0;
    end else begin
      if (clr_en) busy[clr_idx] <= 1'b0;
      // NOTE: with non-blocking assignments the last write in the block wins,
      // which is how set-over-clear priority is expressed here.
      if (set_en) busy[set_idx] <= 1'b1;
    end
  end

endmodule : reg_scoreboard

// File: rtl/reg_read_port.sv
// Read side of the CPU register state: 8 x 16-bit register file with one
// writeback port, a two-operand read port with valid/ready handshake, a
// one-entry registered response buffer and a busy scoreboard.
module reg_read_port
  import reg_read_port_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [AW-1:0]     ra,
  input  logic [AW-1:0]     rb,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_dst,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [NREG-1:0]   busy
);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hazard;
  logic              accept;
  state_t            state;

  reg_scoreboard u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (accept && issue_en),
    .set_idx (issue_dst),
    .clr_en  (wb_en),
    .clr_idx (wb_addr),
    .ra      (ra),
    .rb      (rb),
    .busy    (busy),
    .hazard  (hazard)
  );

  // Operand select with same-cycle writeback bypass.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    op_a = regs[ra];
    op_b = regs[rb];
    if (wb_en && (wb_addr == ra)) op_a = wb_data;
    if (wb_en && (wb_addr == rb)) op_b = wb_data;
  end

  assign resp_valid = (state == FULL);
  assign req_ready  = !hazard && (!resp_valid || resp_ready);
  assign accept     = req_valid && req_ready;

  // Register file writeback; reset clears every architectural register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: this array is reset on purpose because software-visible state
      // must read zero after reset, so it maps to flops rather than a RAM macro.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Response buffer FSM with registered operand outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= EMPTY;
      qa    <= '0;
      qb    <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state <= FULL;
            qa    <= op_a;
            qb    <= op_b;
          end
        end
        FULL: begin
          if (accept) begin
            state <= FULL;
            qa    <= op_a;
            qb    <= op_b;
          end else if (resp_ready) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule : reg_read_port
